// File: rtl/serial_reg_loader.sv
// Serial register loader: accepts parallel words over valid/ready and shifts them MSB-first
// onto the wave, delay or idle chain. Optional readback loopback under LOADER_READBACK_EN.
module serial_reg_loader #(
  parameter int unsigned word_width = 32,
  parameter int unsigned clk_div    = 4
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [word_width-1:0] s_data,
  input  logic [1:0]            s_target,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  wave_reg_sclk,
  output logic                  wave_reg_data_in,
  output logic                  delay_reg_sclk,
  output logic                  delay_reg_data_in,
  output logic                  idle_reg_sclk,
  output logic                  idle_reg_data_in,
`ifdef LOADER_READBACK_EN
  input  logic                  rb_data_in,
  output logic [word_width-1:0] rb_word,
  output logic                  rb_valid,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned DIV_W = $clog2(clk_div + 1);
  localparam int unsigned BIT_W = $clog2(word_width + 1);
  localparam int unsigned MSB   = word_width - 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(clk_div - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(word_width - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [word_width-1:0] shreg_q, shreg_d, shifted;
  logic [1:0]            tgt_q, tgt_d;
  logic                  last_q, last_d;
  logic                  fin_q, fin_d, fin_last_q, fin_last_d, fin_err_q, fin_err_d;
  logic                  sclk_d, bit_out_d, ready_d, accept;
`ifdef LOADER_READBACK_EN
  logic [word_width-1:0] rb_shift_q, rb_shift_d, rb_word_d;
  logic                  rb_valid_d;
`endif

  assign accept  = s_valid && s_ready && (state_q == IDLE);
  assign shifted = shreg_q << 1;

  // Next-state, counters and pre-register values of every output.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    tgt_d      = tgt_q;
    last_d     = last_q;
    fin_d      = 1'b0;
    fin_last_d = 1'b0;
    fin_err_d  = 1'b0;
    sclk_d     = 1'b0;
    bit_out_d  = 1'b0;
`ifdef LOADER_READBACK_EN
    rb_shift_d = rb_shift_q;
    rb_word_d  = rb_word;
    rb_valid_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          div_d = '0;
          bit_d = '0;
          if (s_target == 2'd3) begin
            fin_d      = 1'b1;
            fin_err_d  = 1'b1;
            fin_last_d = s_last;
          end else begin
            state_d   = LOW;
            shreg_d   = s_data;
            tgt_d     = s_target;
            last_d    = s_last;
            bit_out_d = s_data[MSB];
`ifdef LOADER_READBACK_EN
            rb_shift_d = '0;
`endif
          end
        end
      end
      LOW: begin
        bit_out_d = shreg_q[MSB];
        if (div_q == DIV_LAST) begin
          state_d = HIGH;
          div_d   = '0;
          sclk_d  = 1'b1;
`ifdef LOADER_READBACK_EN
          rb_shift_d = word_width'({rb_shift_q, rb_data_in});
`endif
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d    = IDLE;
            fin_d      = 1'b1;
            fin_last_d = last_q;
`ifdef LOADER_READBACK_EN
            rb_word_d  = rb_shift_q;
            rb_valid_d = 1'b1;
`endif
          end else begin
            // Data only changes here, a full LOW phase ahead of the next rise.
            state_d   = LOW;
            bit_d     = bit_q + 1'b1;
            shreg_d   = shifted;
            bit_out_d = shifted[MSB];
          end
        end else begin
          sclk_d    = 1'b1;
          bit_out_d = shreg_q[MSB];
          div_d     = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready drops for one IDLE cycle after a word; invalid targets never drop it.
    ready_d = (state_q == IDLE) && !(accept && (s_target != 2'd3));
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q           <= IDLE;
      div_q             <= '0;
      bit_q             <= '0;
      shreg_q           <= '0;
      tgt_q             <= '0;
      last_q            <= 1'b0;
      fin_q             <= 1'b0;
      fin_last_q        <= 1'b0;
      fin_err_q         <= 1'b0;
      s_ready           <= 1'b1;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      wave_reg_sclk     <= 1'b0;
      wave_reg_data_in  <= 1'b0;
      delay_reg_sclk    <= 1'b0;
      delay_reg_data_in <= 1'b0;
      idle_reg_sclk     <= 1'b0;
      idle_reg_data_in  <= 1'b0;
`ifdef LOADER_READBACK_EN
      rb_shift_q        <= '0;
      rb_word           <= '0;
      rb_valid          <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      div_q             <= div_d;
      bit_q             <= bit_d;
      shreg_q           <= shreg_d;
      tgt_q             <= tgt_d;
      last_q            <= last_d;
      fin_q             <= fin_d;
      fin_last_q        <= fin_last_d;
      fin_err_q         <= fin_err_d;
      s_ready           <= ready_d;
      busy              <= !ready_d;
      done              <= fin_q && fin_last_q;
      err               <= fin_q && fin_err_q;
      wave_reg_sclk     <= sclk_d    && (tgt_d == 2'd0);
      wave_reg_data_in  <= bit_out_d && (tgt_d == 2'd0);
      delay_reg_sclk    <= sclk_d    && (tgt_d == 2'd1);
      delay_reg_data_in <= bit_out_d && (tgt_d == 2'd1);
      idle_reg_sclk     <= sclk_d    && (tgt_d == 2'd2);
      idle_reg_data_in  <= bit_out_d && (tgt_d == 2'd2);
`ifdef LOADER_READBACK_EN
      rb_shift_q        <= rb_shift_d;
      rb_word           <= rb_word_d;
      rb_valid          <= rb_valid_d;
`endif
    end
  end

endmodule
